// File: rtl/prf_pkg.sv
// Shared defaults, derived widths and types for the multi-ported physical register file.
package prf_pkg;

  localparam int DEF_N_PREGS = 64;
  localparam int DEF_XLEN    = 32;
  localparam int DEF_N_RD    = 4;
  localparam int DEF_N_WR    = 3;
  localparam int DEF_N_ALLOC = 2;
  localparam int DEF_N_CKPT  = 8;

  localparam int PW = $clog2(DEF_N_PREGS);
  localparam int CW = $clog2(DEF_N_CKPT);

  typedef logic [PW-1:0]          preg_t;
  typedef logic [CW-1:0]          ckpt_tag_t;
  typedef logic [DEF_N_PREGS-1:0] valid_vec_t;

  typedef enum logic {ST_INIT, ST_RUN} prf_state_e;

endpackage

// File: rtl/prf_valid_ckpt.sv
// Ready-bit vector with snapshot/restore slots; ignores all updates until the init sweep ends.
module prf_valid_ckpt import prf_pkg::*; #(
  parameter int N_PREGS = DEF_N_PREGS,
  parameter int N_WR    = DEF_N_WR,
  parameter int N_ALLOC = DEF_N_ALLOC,
  parameter int N_CKPT  = DEF_N_CKPT
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               run_i,
  input  logic [N_WR-1:0]                    wr_en_i,
  input  logic [N_WR*$clog2(N_PREGS)-1:0]    wr_preg_i,
  input  logic [N_ALLOC-1:0]                 alloc_en_i,
  input  logic [N_ALLOC*$clog2(N_PREGS)-1:0] alloc_preg_i,
  input  logic                               ckpt_take_i,
  input  logic [$clog2(N_CKPT)-1:0]          ckpt_tag_i,
  input  logic                               recover_i,
  input  logic [$clog2(N_CKPT)-1:0]          recover_tag_i,
  input  logic                               flush_i,
  output logic [N_PREGS-1:0]                 valid_o
);

  localparam int IW = $clog2(N_PREGS);
  localparam logic [N_PREGS-1:0] PREG0 = N_PREGS'(1);

  logic [N_PREGS-1:0] valid_q, valid_d;
  logic [N_PREGS-1:0] wr_mask, alloc_mask;
  logic [N_PREGS-1:0] slot_q [N_CKPT];

  always_comb begin
    wr_mask    = '0;
    alloc_mask = '0;
    for (int unsigned w = 0; w < N_WR; w++)
      if (wr_en_i[w]) wr_mask[wr_preg_i[w*IW +: IW]] = 1'b1;
    for (int unsigned a = 0; a < N_ALLOC; a++)
      if (alloc_en_i[a]) alloc_mask[alloc_preg_i[a*IW +: IW]] = 1'b1;
    alloc_mask[0] = 1'b0;
    valid_d = (valid_q & ~alloc_mask) | wr_mask;
  end

  // Snapshots are taken only on the normal path, so recover/flush suppress them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '1;
      for (int unsigned i = 0; i < N_CKPT; i++) slot_q[i] <= '1;
    end else if (run_i) begin
      if (recover_i) begin
        valid_q <= slot_q[recover_tag_i] | wr_mask | PREG0;
      end else if (flush_i) begin
        valid_q <= '1;
      end else begin
        valid_q <= valid_d;
        if (ckpt_take_i) slot_q[ckpt_tag_i] <= valid_d;
      end
    end
  end

  assign valid_o = valid_q;

endmodule

// File: rtl/prf_mp.sv
// Physical register file: data storage with write bypass and a post-reset clearing sweep.
module prf_mp import prf_pkg::*; #(
  parameter int N_PREGS = DEF_N_PREGS,
  parameter int XLEN    = DEF_XLEN,
  parameter int N_RD    = DEF_N_RD,
  parameter int N_WR    = DEF_N_WR,
  parameter int N_ALLOC = DEF_N_ALLOC,
  parameter int N_CKPT  = DEF_N_CKPT
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [N_RD*$clog2(N_PREGS)-1:0]    raddr_i,
  output logic [N_RD*XLEN-1:0]               rdata_o,
  input  logic [N_WR-1:0]                    wr_en_i,
  input  logic [N_WR*$clog2(N_PREGS)-1:0]    wr_preg_i,
  input  logic [N_WR*XLEN-1:0]               wr_data_i,
  input  logic [N_ALLOC-1:0]                 alloc_en_i,
  input  logic [N_ALLOC*$clog2(N_PREGS)-1:0] alloc_preg_i,
  input  logic                               ckpt_take_i,
  input  logic [$clog2(N_CKPT)-1:0]          ckpt_tag_i,
  input  logic                               recover_i,
  input  logic [$clog2(N_CKPT)-1:0]          recover_tag_i,
  input  logic                               flush_i,
  output logic [N_PREGS-1:0]                 valid_o,
  output logic                               init_busy_o
);

  localparam int IW = $clog2(N_PREGS);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_PREGS - 1);

  prf_state_e        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [XLEN-1:0]   mem_q [N_PREGS];
  logic              run;

  assign run         = (state_q == ST_RUN);
  assign init_busy_o = (state_q == ST_INIT);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_INIT: begin
        if (idx_q == LAST_IDX) state_d = ST_RUN;
        else                   idx_d   = idx_q + IW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      idx_q   <= IW'(1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // No data reset: entries 1..N-1 are zeroed by the sweep, entry 0 is never read.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem_q[idx_q] <= '0;
    end else begin
      for (int unsigned w = 0; w < N_WR; w++)
        if (wr_en_i[w] && (wr_preg_i[w*IW +: IW] != '0))
          mem_q[wr_preg_i[w*IW +: IW]] <= wr_data_i[w*XLEN +: XLEN];
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int unsigned r = 0; r < N_RD; r++) begin
      if (run && (raddr_i[r*IW +: IW] != '0)) begin
        rdata_o[r*XLEN +: XLEN] = mem_q[raddr_i[r*IW +: IW]];
        for (int unsigned w = 0; w < N_WR; w++)
          if (wr_en_i[w] && (wr_preg_i[w*IW +: IW] == raddr_i[r*IW +: IW]))
            rdata_o[r*XLEN +: XLEN] = wr_data_i[w*XLEN +: XLEN];
      end
    end
  end

  prf_valid_ckpt #(
    .N_PREGS (N_PREGS),
    .N_WR    (N_WR),
    .N_ALLOC (N_ALLOC),
    .N_CKPT  (N_CKPT)
  ) u_valid (
    .clk           (clk),
    .rst_n         (rst_n),
    .run_i         (run),
    .wr_en_i       (wr_en_i),
    .wr_preg_i     (wr_preg_i),
    .alloc_en_i    (alloc_en_i),
    .alloc_preg_i  (alloc_preg_i),
    .ckpt_take_i   (ckpt_take_i),
    .ckpt_tag_i    (ckpt_tag_i),
    .recover_i     (recover_i),
    .recover_tag_i (recover_tag_i),
    .flush_i       (flush_i),
    .valid_o       (valid_o)
  );

endmodule

// File: doc/prf_mp.md
PRF_MP -- requirements
Module: prf_mp

Interface
REQ-001 Parameter N_PREGS, default 64, physical register count (power of 2, >=8).
REQ-002 Parameter XLEN, default 32, data width.
REQ-003 Parameter N_RD, default 4, combinational read ports.
REQ-004 Parameter N_WR, default 3, writeback ports.
REQ-005 Parameter N_ALLOC, default 2, allocation-invalidate ports.
REQ-006 Parameter N_CKPT, default 8, valid-bit checkpoint slots; PW=clog2(N_PREGS), CW=clog2(N_CKPT).
REQ-007 Clock and reset: clk input 1 rising-edge clock; rst_n input 1 reset, synchronous, active-low.
REQ-008 raddr_i input N_RD*PW read addresses; rdata_o output N_RD*XLEN read data.
REQ-009 wr_en_i input N_WR; wr_preg_i input N_WR*PW; wr_data_i input N_WR*XLEN writeback ports.
REQ-010 alloc_en_i input N_ALLOC; alloc_preg_i input N_ALLOC*PW newly allocated destinations.
REQ-011 ckpt_take_i input 1; ckpt_tag_i input CW snapshot request and slot.
REQ-012 recover_i input 1; recover_tag_i input CW restore request and slot.
REQ-013 flush_i input 1 full pipeline flush.
REQ-014 valid_o output N_PREGS registered ready bits; init_busy_o output 1 high during init sweep.

Function
REQ-015 Preg 0 SHALL always read 0, report valid, and ignore writes, allocs and restores.
REQ-016 Reads SHALL be combinational; a same-cycle write to the read preg SHALL bypass wr_data_i to rdata_o.
REQ-017 Writes SHALL update storage at the clock edge; two write ports targeting the same nonzero preg in one cycle is illegal (bench assertion).
REQ-018 valid_next = (valid_o & ~alloc_mask) | wr_mask; a write wins over an alloc to the same preg in the same cycle.
REQ-019 ckpt_take_i SHALL store valid_next into slot ckpt_tag_i at the edge, so the snapshot includes that cycle's allocs and writes.
REQ-020 recover_i SHALL load valid_o <= slot[recover_tag_i] | wr_mask; allocs that cycle are dropped; data writes still commit; storage data is never restored.
REQ-021 flush_i SHALL set all valid_o bits to 1; data writes still commit; allocs dropped.
REQ-022 Priority: init sweep > recover_i > flush_i > normal; ckpt_take_i coincident with recover_i or flush_i SHALL be ignored.
REQ-023 FSM states INIT and RUN; INIT clears one preg per cycle via counter idx from 1 to N_PREGS-1, then enters RUN.
REQ-024 In INIT: init_busy_o=1, all write, alloc, checkpoint, recover and flush inputs ignored, rdata_o=0, valid_o all ones.
REQ-025 Sweep SHALL take exactly N_PREGS-1 cycles after rst_n rises; init_busy_o falls in the cycle RUN is entered.
REQ-026 Checkpoint slots SHALL be independent; retaking a slot overwrites it; recovering from a never-written slot returns all ones.

Reset
REQ-027 rst_n low SHALL set state INIT, idx=1, valid_o all ones, init_busy_o=1, and all checkpoint slots to all ones.
REQ-028 rst_n asserted mid-sweep SHALL restart the sweep at idx=1.
REQ-029 Data storage SHALL not be reset directly; it is cleared only by the sweep.

Structure
REQ-030 Shared package prf_pkg SHALL hold the default parameters, PW/CW derivations and typedefs preg_t, ckpt_tag_t and valid_vec_t.
REQ-031 One sub-module, prf_valid_ckpt, SHALL own valid_o, the checkpoint slot array and the REQ-018..REQ-022 logic; prf_mp holds storage, bypass and FSM.

Verification
REQ-032 Reset, then count cycles -> init_busy_o high for exactly 63 cycles (N_PREGS=64); rdata_o=0 for all pregs afterwards.
REQ-033 Write preg 5=0xDEADBEEF on port 2 while reading preg 5 on port 0 -> rdata_o[0]=0xDEADBEEF the same cycle and after the edge.
REQ-034 Alloc preg 9 and write preg 9 in the same cycle -> valid_o[9]=1 next cycle; alloc preg 9 alone -> valid_o[9]=0.
REQ-035 Alloc preg 10, checkpoint slot 3, alloc preg 11, then recover slot 3 while writing preg 12 -> valid_o[10]=0, [11]=1, [12]=1.
REQ-036 With valid_o[20]=0, flush_i plus an alloc of preg 21 -> all valid_o bits =1.
REQ-037 Write preg 0=0x1234 and recover_i during INIT -> preg 0 reads 0, no state change, and the sweep completes on schedule.
